// File: rtl/seq_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_scan_pkg
//  Description : Shared definitions for the sequence-scan controller:
//                2-bit FSM state encoding, default detection pattern and
//                length, and a helper that builds the pattern compare mask.
//  Revision    : 1.0  initial release
// ============================================================================
package seq_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Default pattern 1110010, right-aligned; MSB of the valid field is oldest.
    localparam logic [7:0] c_DEF_PATTERN = 8'b0111_0010;
    localparam int         c_DEF_PAT_LEN = 7;

    // Mask selecting the low n bits (n in 1..8).
    function automatic logic [7:0] pat_mask(input int n);
        logic [8:0] m;
        m = (9'd1 << n) - 9'd1;
        return m[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_det_core.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_core
//  Description : Serial pattern detector. Keeps a shift history of the most
//                recent bits plus a fill counter so that a match is only
//                reported once PAT_LEN bits have been seen since the last
//                clear. Overlapping matches are all reported.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                clr        - clear history and fill count (job start)
//                bit_en     - bit_in is valid this cycle
//                bit_in     - serial bit, oldest first
//                hit        - combinational: this cycle's bit completes a match
//                match      - registered hit (one-cycle pulse, next cycle)
//  Revision    : 1.0  initial release
// ============================================================================
module seq_det_core
    import seq_scan_pkg::*;
#(
    parameter logic [7:0] PATTERN = c_DEF_PATTERN,
    parameter int         PAT_LEN = c_DEF_PAT_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic bit_en,
    input  logic bit_in,
    output logic hit,
    output logic match
);

    localparam logic [7:0] c_MASK = pat_mask(PAT_LEN);
    // Bits that must already be in the history before the current bit.
    localparam logic [3:0] c_NEED = 4'(PAT_LEN - 1);

    logic [6:0] r_hist;
    logic [3:0] r_fill;
    logic       r_match;
    logic [7:0] w_window;
    logic       w_hit;

    // Window = history followed by the incoming bit (newest in bit 0).
    assign w_window = {r_hist, bit_in};
    assign w_hit    = bit_en && (r_fill >= c_NEED) &&
                      ((w_window & c_MASK) == (PATTERN & c_MASK));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else begin
            r_match <= w_hit;
            if (clr) begin
                r_hist <= '0;
                r_fill <= '0;
            end else if (bit_en) begin
                r_hist <= w_window[6:0];
                if (r_fill != 4'd8) begin
                    r_fill <= r_fill + 4'd1;
                end
            end
        end
    end

    assign hit   = w_hit;
    assign match = r_match;

endmodule
`default_nettype wire

// File: rtl/seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seq_scan_ctrl
//  Description : Scan-job controller. A job of len words is accepted one
//                word at a time (LOAD), each word is shifted MSB-first into
//                a serial pattern detector (SHIFT, 8 cycles), and a one-cycle
//                done pulse closes the job. Matches are pulsed and counted
//                (saturating) per job.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                start, len          - job request and word count
//                din_valid, din      - input word stream
//                din_ready           - word accepted this cycle when valid
//                busy, done          - job status / completion pulse
//                match_pulse         - one pulse per detected pattern
//                match_cnt           - matches in current/last job
//                abort               - only with SEQ_SCAN_ABORT_EN defined:
//                                      drop the job from LOAD/SHIFT, no done
//  Config      : SEQ_SCAN_ABORT_EN   - adds the abort input
//  Revision    : 1.0  initial release
// ============================================================================
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter logic [7:0] PATTERN = c_DEF_PATTERN,
    parameter int         PAT_LEN = c_DEF_PAT_LEN,
    parameter int         CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       len,
`ifdef SEQ_SCAN_ABORT_EN
    input  logic             abort,
`endif
    input  logic             din_valid,
    input  logic [7:0]       din,
    output logic             din_ready,
    output logic             busy,
    output logic             done,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    state_t           r_state;
    logic [7:0]       r_words_left;
    logic [7:0]       r_shreg;
    logic [2:0]       r_bit_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             r_busy;
    logic             r_din_ready;

    logic w_abort;
    logic w_bit_en;
    logic w_clr;
    logic w_hit;
    logic w_match;

`ifdef SEQ_SCAN_ABORT_EN
    assign w_abort = abort && ((r_state == ST_LOAD) || (r_state == ST_SHIFT));
`else
    assign w_abort = 1'b0;
`endif

    // An aborted cycle shifts nothing, so no match can be counted on it.
    assign w_bit_en = (r_state == ST_SHIFT) && !w_abort;
    assign w_clr    = (r_state == ST_IDLE) && start;

    seq_det_core #(
        .PATTERN (PATTERN),
        .PAT_LEN (PAT_LEN)
    ) u_det (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_clr),
        .bit_en (w_bit_en),
        .bit_in (r_shreg[r_bit_idx]),
        .hit    (w_hit),
        .match  (w_match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_words_left <= '0;
            r_shreg      <= '0;
            r_bit_idx    <= '0;
            r_cnt        <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_din_ready  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        if (len != 8'd0) begin
                            r_state      <= ST_LOAD;
                            r_words_left <= len;
                            r_din_ready  <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_abort) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_din_ready <= 1'b0;
                    end else if (din_valid && r_din_ready) begin
                        r_shreg     <= din;
                        r_bit_idx   <= 3'd7;
                        r_state     <= ST_SHIFT;
                        r_din_ready <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        // Counter moves on the same edge the match pulse rises.
                        if (w_hit && (r_cnt != c_CNT_MAX)) begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                        if (r_bit_idx == 3'd0) begin
                            r_words_left <= r_words_left - 8'd1;
                            if (r_words_left == 8'd1) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state     <= ST_LOAD;
                                r_din_ready <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx - 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_din_ready <= 1'b0;
                end
            endcase
        end
    end

    assign din_ready   = r_din_ready;
    assign busy        = r_busy;
    assign done        = r_done;
    assign match_pulse = w_match;
    assign match_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_scan_ctrl
//  Description : Self-checking bench for seq_scan_ctrl. Two instances share
//                all inputs: one with the default counter width, one with a
//                2-bit counter to exercise saturation. A stream-level model
//                predicts every output each cycle; directed jobs add literal
//                expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_scan_ctrl;

    localparam logic [6:0] c_PAT = 7'b1110010;
    localparam int         c_PL  = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] len = 8'd0;
    logic       din_valid = 1'b0;
    logic [7:0] din = 8'd0;

    logic       ready_a, busy_a, done_a, pulse_a;
    logic [7:0] cnt_a;
    logic       ready_b, busy_b, done_b, pulse_b;
    logic [1:0] cnt_b;

    always #5 clk = ~clk;

    seq_scan_ctrl dut_a (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len         (len),
        .din_valid   (din_valid),
        .din         (din),
        .din_ready   (ready_a),
        .busy        (busy_a),
        .done        (done_a),
        .match_pulse (pulse_a),
        .match_cnt   (cnt_a)
    );

    seq_scan_ctrl #(.CNT_W(2)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len         (len),
        .din_valid   (din_valid),
        .din         (din),
        .din_ready   (ready_b),
        .busy        (busy_b),
        .done        (done_b),
        .match_pulse (pulse_b),
        .match_cnt   (cnt_b)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int np_a     = 0;   // running total of match pulses seen
    int nd_a     = 0;   // running total of done pulses seen
    bit chk_on   = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // ---------------- stream-level model ----------------
    // phase: 0 idle, 1 waiting for a word, 2 emitting word bits, 3 done
    int         m_phase = 0;
    int         m_words = 0;
    int         m_left  = 0;
    int         m_nbits = 0;
    logic [7:0] m_word  = 8'd0;
    logic [31:0] m_hist = 32'd0;
    logic       bitv;
    bit         e_ready = 0, e_busy = 0, e_done = 0, e_pulse = 0;
    int         e_cnt_a = 0, e_cnt_b = 0;

    always @(posedge clk) begin
        e_done  = 1'b0;
        e_pulse = 1'b0;
        if (rst) begin
            m_phase = 0; e_ready = 0; e_busy = 0;
            e_cnt_a = 0; e_cnt_b = 0; m_nbits = 0; m_hist = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    e_cnt_a = 0; e_cnt_b = 0; m_nbits = 0; m_hist = 0;
                    e_busy = 1;
                    if (len == 8'd0) begin
                        m_phase = 3; e_done = 1;
                    end else begin
                        m_words = int'(len); m_phase = 1; e_ready = 1;
                    end
                end
                1: if (din_valid) begin
                    m_word = din; m_left = 8; m_phase = 2; e_ready = 0;
                end
                2: begin
                    bitv = m_word[m_left-1];
                    m_hist = {m_hist[30:0], bitv};
                    m_nbits++;
                    if (m_nbits >= c_PL && m_hist[6:0] == c_PAT) begin
                        e_pulse = 1;
                        if (e_cnt_a < 255) e_cnt_a++;
                        if (e_cnt_b < 3)   e_cnt_b++;
                    end
                    m_left--;
                    if (m_left == 0) begin
                        m_words--;
                        if (m_words == 0) begin
                            m_phase = 3; e_done = 1;
                        end else begin
                            m_phase = 1; e_ready = 1;
                        end
                    end
                end
                default: begin
                    m_phase = 0; e_busy = 0;
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            chk("din_ready_a",   ready_a, e_ready);
            chk("busy_a",        busy_a,  e_busy);
            chk("done_a",        done_a,  e_done);
            chk("match_pulse_a", pulse_a, e_pulse);
            chk("match_cnt_a",   cnt_a,   e_cnt_a);
            chk("din_ready_b",   ready_b, e_ready);
            chk("busy_b",        busy_b,  e_busy);
            chk("done_b",        done_b,  e_done);
            chk("match_pulse_b", pulse_b, e_pulse);
            chk("match_cnt_b",   cnt_b,   e_cnt_b);
            np_a += int'(pulse_a);
            nd_a += int'(done_a);
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic do_start(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d, output int acc);
        int k = 0;
        while (!ready_a && k < 60) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (!ready_a) begin
            n_err++;
            $display("FAIL din_ready_timeout: din_ready=%0d after 60 cycles, expected 1", ready_a);
        end
        din_valid = 1'b1;
        din       = d;
        acc       = cyc;
        @(negedge clk);
        din_valid = 1'b0;
        din       = 8'd0;
    endtask

    task automatic wait_done(input string nm, output int c);
        bit got = 1'b0;
        c = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (done_a) begin
                got = 1'b1;
                c   = cyc;
            end
        end
        n_checks++;
        if (!got) begin
            n_err++;
            $display("FAIL %s_timeout: done=0 for 60 cycles, expected 1", nm);
        end
    endtask

    // ---------------- directed jobs ----------------
    initial begin
        int acc, dc, p0, d0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy",      busy_a,  0);
        chk("rst_din_ready", ready_a, 0);
        chk("rst_done",      done_a,  0);
        chk("rst_cnt",       cnt_a,   0);
        chk("rst_pulse",     pulse_a, 0);
        chk_on = 1'b1;
        rst    = 1'b0;

        // Single word E4: one match, done 9 cycles after acceptance.
        p0 = np_a;
        do_start(8'd1);
        send_word(8'hE4, acc);
        wait_done("t1", dc);
        chk("t1_latency", dc - acc, 9);
        chk("t1_cnt",     cnt_a, 1);
        @(negedge clk);
        chk("t1_pulses",  np_a - p0, 1);

        // Pattern spanning a word boundary: 0E then 40.
        p0 = np_a;
        do_start(8'd2);
        send_word(8'h0E, acc);
        send_word(8'h40, acc);
        wait_done("t2", dc);
        chk("t2_cnt", cnt_a, 1);
        @(negedge clk);
        chk("t2_pulses", np_a - p0, 1);

        // Zero-length job: done immediately, counter cleared, never ready.
        do_start(8'd0);
        chk("t3_done",  done_a,  1);
        chk("t3_cnt",   cnt_a,   0);
        chk("t3_ready", ready_a, 0);
        @(negedge clk);

        // Stall in LOAD for 5 cycles, then resume.
        do_start(8'd1);
        repeat (5) @(negedge clk);
        chk("t4_ready_held", ready_a, 1);
        chk("t4_busy",       busy_a,  1);
        chk("t4_cnt",        cnt_a,   0);
        send_word(8'hE4, acc);
        wait_done("t4", dc);
        chk("t4_cnt_final", cnt_a, 1);
        @(negedge clk);

        // Four E4 words: 4 matches, 2-bit counter saturates at 3.
        // A start pulse mid-job must be ignored.
        p0 = np_a;
        do_start(8'd4);
        send_word(8'hE4, acc);
        start = 1'b1;
        len   = 8'd3;
        @(negedge clk);
        start = 1'b0;
        len   = 8'd0;
        send_word(8'hE4, acc);
        send_word(8'hE4, acc);
        send_word(8'hE4, acc);
        wait_done("t5", dc);
        chk("t5_cnt_a", cnt_a, 4);
        chk("t5_cnt_b", cnt_b, 3);
        @(negedge clk);
        chk("t5_pulses", np_a - p0, 4);

        // Reset mid-SHIFT: job discarded, no done; next job still works.
        do_start(8'd1);
        send_word(8'hE4, acc);
        repeat (3) @(negedge clk);
        d0  = nd_a;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_busy", busy_a, 0);
        chk("t6_cnt",  cnt_a,  0);
        repeat (12) @(negedge clk);
        chk("t6_no_done", nd_a - d0, 0);
        do_start(8'd1);
        send_word(8'hE4, acc);
        wait_done("t6", dc);
        chk("t6_cnt_final", cnt_a, 1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
